z_core_muldiv_unit: RTL and testbench

Z_CORE_MULDIV_UNIT -- requirements
Module: z_core_muldiv_unit

---
 rtl/z_core_muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_z_core_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/z_core_muldiv_unit.sv
// Integer multiply/divide unit: one-cycle 2*XLEN multiply, radix-2 restoring divide,
// valid/ready handshakes on both sides, opaque tag passthrough and flush.
module z_core_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);
   localparam int CNT_W = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic [XLEN-1:0] f_neg_if(input logic [XLEN-1:0] v, input logic neg);
      if (neg) f_neg_if = {XLEN{1'b0}} - v;
      else     f_neg_if = v;
   endfunction

   // Magnitude of a two's-complement value; MIN_VAL maps onto itself, which is its unsigned magnitude.
   function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] v, input logic is_signed);
      f_mag = f_neg_if(v, is_signed & v[XLEN-1]);
   endfunction

   state_t             r_state;
   state_t             w_next;
   logic [1:0]         r_op;
   logic [XLEN-1:0]    r_a;
   logic [XLEN-1:0]    r_b;
   logic [TAG_W-1:0]   r_tag;
   logic [XLEN-1:0]    r_quo;
   logic [XLEN-1:0]    r_rem;
   logic [XLEN-1:0]    r_dvs;
   logic               r_neg_q;
   logic               r_neg_r;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_out_valid;
   logic [XLEN-1:0]    r_out_data;

   logic               w_b_zero;
   logic               w_ovf;
   logic               w_special;
   logic               w_sdiv;
   logic [XLEN-1:0]    w_special_res;
   logic               w_a_sgn;
   logic               w_b_sgn;
   logic [2*XLEN-1:0]  w_mul_a;
   logic [2*XLEN-1:0]  w_mul_b;
   logic [2*XLEN-1:0]  w_prod;
   logic [XLEN-1:0]    w_mul_res;
   logic [XLEN:0]      w_trial;
   logic               w_ge;
   logic [XLEN-1:0]    w_rem_sub;
   logic               w_div_last;
   logic [XLEN-1:0]    w_div_res;

   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_tag   = r_tag;

   // Signed ops are DIV (100) and REM (110); divide-by-zero and MIN/-1 bypass the iteration.
   assign w_sdiv    = ~in_op[0];
   assign w_b_zero  = (in_b == {XLEN{1'b0}});
   assign w_ovf     = w_sdiv & (in_a == MIN_VAL) & (in_b == {XLEN{1'b1}});
   assign w_special = in_op[2] & (w_b_zero | w_ovf);

   // Immediate result for the divide special cases.
   always_comb begin
      w_special_res = in_a;
      if (w_b_zero) begin
         if (in_op[1]) w_special_res = in_a;
         else          w_special_res = {XLEN{1'b1}};
      end else begin
         if (in_op[1]) w_special_res = {XLEN{1'b0}};
         else          w_special_res = in_a;
      end
   end

   assign w_a_sgn   = (r_op == 2'b01) | (r_op == 2'b10);
   assign w_b_sgn   = (r_op == 2'b01);
   assign w_mul_a   = {{XLEN{r_a[XLEN-1] & w_a_sgn}}, r_a};
   assign w_mul_b   = {{XLEN{r_b[XLEN-1] & w_b_sgn}}, r_b};
   assign w_prod    = w_mul_a * w_mul_b;
   assign w_mul_res = (r_op == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   // The partial remainder stays below the divisor, so the subtraction fits in XLEN bits.
   assign w_trial    = {r_rem, r_quo[XLEN-1]};
   assign w_ge       = (w_trial >= {1'b0, r_dvs});
   assign w_rem_sub  = w_trial[XLEN-1:0] - r_dvs;
   assign w_div_last = (r_cnt == CNT_W'(XLEN));
   assign w_div_res  = r_op[1] ? f_neg_if(r_rem, r_neg_r) : f_neg_if(r_quo, r_neg_q);

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic; flush overrides everything.
   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (!in_op[2])      w_next = ST_MUL;
                  else if (w_special) w_next = ST_DONE;
                  else                w_next = ST_DIV;
               end else begin
                  w_next = ST_IDLE;
               end
            end
            ST_MUL:  w_next = ST_DONE;
            ST_DIV: begin
               if (w_div_last) w_next = ST_DONE;
               else            w_next = ST_DIV;
            end
            ST_DONE: begin
               if (out_ready) w_next = ST_IDLE;
               else           w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   // Operand capture, divide iteration and registered result.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_op        <= 2'b00;
         r_a         <= {XLEN{1'b0}};
         r_b         <= {XLEN{1'b0}};
         r_tag       <= {TAG_W{1'b0}};
         r_quo       <= {XLEN{1'b0}};
         r_rem       <= {XLEN{1'b0}};
         r_dvs       <= {XLEN{1'b0}};
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_cnt       <= {CNT_W{1'b0}};
         r_out_valid <= 1'b0;
         r_out_data  <= {XLEN{1'b0}};
      end else if (flush) begin
         r_cnt       <= {CNT_W{1'b0}};
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_op    <= in_op[1:0];
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_tag   <= in_tag;
                  r_quo   <= f_mag(in_a, w_sdiv);
                  r_dvs   <= f_mag(in_b, w_sdiv);
                  r_rem   <= {XLEN{1'b0}};
                  r_neg_q <= w_sdiv & (in_a[XLEN-1] ^ in_b[XLEN-1]);
                  r_neg_r <= w_sdiv & in_a[XLEN-1];
                  r_cnt   <= {CNT_W{1'b0}};
                  if (w_special) begin
                     r_out_data  <= w_special_res;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
               r_out_data  <= w_mul_res;
               r_out_valid <= 1'b1;
            end
            ST_DIV: begin
               if (w_div_last) begin
                  r_out_data  <= w_div_res;
                  r_out_valid <= 1'b1;
               end else begin
                  r_quo <= {r_quo[XLEN-2:0], w_ge};
                  r_rem <= w_ge ? w_rem_sub : w_trial[XLEN-1:0];
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
            default: r_out_valid <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_z_core_muldiv_unit.sv
// Self-checking bench: latency/result reference model compared every cycle, plus
// directed literal cases, backpressure, flush, mid-operation reset and random traffic.
module tb_z_core_muldiv_unit;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = 3'd0;
   logic [31:0] in_a = 32'd0;
   logic [31:0] in_b = 32'd0;
   logic [4:0]  in_tag = 5'd0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [4:0]  out_tag;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   z_core_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural result of an operation, from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, sq;
      logic [63:0] ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * $signed(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4, 3'd6: begin
            if (b == 32'd0) return (op == 3'd4) ? 32'hFFFF_FFFF : a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == 3'd4) ? a : 32'd0;
            sq = (op == 3'd4) ? (sa / sb) : (sa % sb);
            return sq[31:0];
         end
         default: begin
            if (b == 32'd0) return (op == 3'd5) ? 32'hFFFF_FFFF : a;
            p = (op == 3'd5) ? (ua / ub) : (ua % ub);
            return p[31:0];
         end
      endcase
   endfunction

   // Edges from acceptance (counted as edge 1) until out_valid is seen high.
   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return 2;
      if (b == 32'd0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Reference model: busy flag, countdown to result, held result/tag.
   bit          m_busy = 1'b0;
   bit          m_valid = 1'b0;
   logic [31:0] m_data = 32'd0;
   logic [4:0]  m_tag = 5'd0;
   int          m_wait = 0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_busy <= 1'b0; m_valid <= 1'b0; m_data <= 32'd0; m_tag <= 5'd0; m_wait <= 0;
      end else if (flush) begin
         m_busy <= 1'b0; m_valid <= 1'b0; m_wait <= 0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy  <= 1'b1;
            m_data  <= ref_res(in_op, in_a, in_b);
            m_tag   <= in_tag;
            m_wait  <= ref_lat(in_op, in_a, in_b) - 1;
            m_valid <= (ref_lat(in_op, in_a, in_b) == 1);
         end
      end else if (m_valid) begin
         if (out_ready) begin m_busy <= 1'b0; m_valid <= 1'b0; end
      end else begin
         m_wait  <= m_wait - 1;
         m_valid <= (m_wait == 1);
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rstn) begin
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_out_data", 64'(out_data), 64'd0);
         chk("rst_out_tag", 64'(out_tag), 64'd0);
      end else begin
         chk("cyc_in_ready", 64'(in_ready), 64'(!m_busy));
         chk("cyc_busy", 64'(busy), 64'(m_busy));
         chk("cyc_out_valid", 64'(out_valid), 64'(m_valid));
         if (m_valid) begin
            chk("cyc_out_data", 64'(out_data), 64'(m_data));
            chk("cyc_out_tag", 64'(out_tag), 64'(m_tag));
         end
      end
   end

   task automatic run_op(input bit pre, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input int stall, input logic [31:0] exp,
                         input int exp_lat, input string nm);
      int lat;
      bit got;
      if (!pre) begin
         @(negedge clk);
         in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
      end
      out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 100) begin
         @(negedge clk);
         lat++;
         if (out_valid) begin
            got = 1'b1;
         end else begin
            in_valid = 1'($urandom_range(0, 1));
            in_op = 3'($urandom_range(0, 7)); in_a = $urandom; in_b = $urandom; in_tag = 5'($urandom);
         end
      end
      in_valid = 1'b0;
      chk({nm, "_done"}, 64'(got), 64'd1);
      if (got) begin
         chk({nm, "_data"}, 64'(out_data), 64'(exp));
         chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
         chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
         repeat (stall) begin
            @(negedge clk);
            chk({nm, "_hold_data"}, 64'(out_data), 64'(exp));
            chk({nm, "_hold_tag"}, 64'(out_tag), 64'(tag));
            chk({nm, "_hold_ready"}, 64'(in_ready), 64'd0);
            chk({nm, "_hold_busy"}, 64'(busy), 64'd1);
         end
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          sel;

      // Request waiting during reset is taken on the first edge after release.
      in_valid = 1'b1; in_op = 3'd3; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_tag = 5'd9;
      repeat (3) @(negedge clk);
      #1 rstn = 1'b1;
      run_op(1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 0, 32'hFFFF_FFFE, 2, "mulhu_first");

      run_op(1'b0, 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, 0, 32'h4000_0000, 2, "mulh");
      run_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0, 32'h0000_0001, 2, "mul");
      run_op(1'b0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 0, 32'hFFFF_FFFF, 2, "mulhsu");
      run_op(1'b0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 32'hFFFF_FFFD, 34, "div_neg");
      run_op(1'b0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, 32'hFFFF_FFFF, 34, "rem_neg");
      run_op(1'b0, 3'd5, 32'd100, 32'd7, 5'd8, 0, 32'd14, 34, "divu");
      run_op(1'b0, 3'd7, 32'd100, 32'd7, 5'd10, 0, 32'd2, 34, "remu");
      run_op(1'b0, 3'd5, 32'd7, 32'd0, 5'd11, 0, 32'hFFFF_FFFF, 1, "divu_zero");
      run_op(1'b0, 3'd7, 32'd7, 32'd0, 5'd12, 0, 32'd7, 1, "remu_zero");
      run_op(1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, 32'h8000_0000, 1, "div_ovf");
      run_op(1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0, 32'd0, 1, "rem_ovf");
      run_op(1'b0, 3'd4, 32'd7, 32'hFFFF_FFFE, 5'd15, 0, 32'hFFFF_FFFD, 34, "div_negdvs");
      run_op(1'b0, 3'd0, 32'd6, 32'd7, 5'd16, 5, 32'd42, 2, "mul_bp");

      // Flush on the tenth cycle of a divide.
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'd5; in_a = 32'd1000; in_b = 32'd3; in_tag = 5'd17;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      repeat (40) @(negedge clk);
      run_op(1'b0, 3'd0, 32'd3, 32'd4, 5'd18, 0, 32'd12, 2, "mul_after_flush");

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'd4; in_a = 32'd12345; in_b = 32'd7; in_tag = 5'd19;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (20) @(negedge clk);
      #1 rstn = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_out_data", 64'(out_data), 64'd0);
      chk("arst_out_tag", 64'(out_tag), 64'd0);
      @(negedge clk);
      #1 rstn = 1'b1;
      run_op(1'b0, 3'd5, 32'd9, 32'd3, 5'd20, 0, 32'd3, 34, "divu_after_rst");

      for (int i = 0; i < 60; i++) begin
         op  = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 15));
         run_op(1'b0, op, a, b, 5'($urandom), $urandom_range(0, 3),
                ref_res(op, a, b), ref_lat(op, a, b), "rand");
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
